pipe_stage_hs_reg: RTL and testbench
====================================

// Module: pipe_stage_hs_reg
// PURPOSE
//   Parametrised pipeline stage register with valid/ready handshake, flush and bubble insertion.
//   Generic replacement for the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   Control bits are forced to a bubble value whenever the stage is empty or flushed.
//   A saturating stall counter supports performance analysis.
// PARAMETERS
//   DATA_W       32*4  payload width (operands, immediates, PCs); never gated on bubble
//   CTRL_W       12    control width (wreg, m2reg, wmem, aluc, ...); replaced by CTRL_BUBBLE when empty
//   CTRL_BUBBLE  0     control value presented while out_valid=0 (must encode "no side effect")
//   CNT_W        16    stall counter width
// PORTS
//   clk        in   1       clock, all state updates on posedge
//   clr        in   1       synchronous active-high reset
//   in_valid   in   1       upstream beat present
//   in_ready   out  1       stage can accept a beat this cycle
//   in_ctrl    in   CTRL_W  upstream control bits
//   in_data    in   DATA_W  upstream payload
//   flush      in   1       sync kill of all held and incoming beats (branch/jump redirect)
//   out_valid  out  1       beat presented downstream
//   out_ready  in   1       downstream accepts (0 = stall)
//   out_ctrl   out  CTRL_W  control; CTRL_BUBBLE when out_valid=0
//   out_data   out  DATA_W  payload; holds last loaded value when out_valid=0
//   stall_cnt  out  CNT_W   cycles with out_valid=1 && out_ready=0, saturating
// BEHAVIOUR
//   - Accept: in_valid && in_ready at posedge. Release: out_valid && out_ready at posedge.
//   - Reset (clr=1 at posedge): out_valid=0, out_ctrl=CTRL_BUBBLE, out_data=0, stall_cnt=0,
//     all entries dropped, in_ready=1 from next cycle. clr overrides flush and handshakes.
//   - Latency 1 cycle in->out; throughput 1 beat/cycle when out_ready=1; order preserved.
//   - Base mode: one entry. in_ready = !out_valid || out_ready (combinational from out_ready).
//     Full and simultaneous accept+release: new beat replaces old, out_valid stays 1.
//     Full and out_ready=0: entry held, in_ready=0, out_* stable.
//   - flush=1 at posedge: every held entry and any beat accepted that cycle discarded;
//     next cycle out_valid=0, out_ctrl=CTRL_BUBBLE. in_ready not masked by flush.
//     A release in the flush cycle still completes (downstream owns that beat).
//   - out_ctrl is registered ctrl ANDed with valid (muxed to CTRL_BUBBLE); never glitches a
//     write-enable high while out_valid=0.
//   - stall_cnt: +1 per cycle with out_valid && !out_ready; stops at 2^CNT_W-1; cleared only by clr.
//   - No X propagation: in_data/in_ctrl only sampled on accept.
// CONFIGURATION
//   PIPE_STAGE_SKID_EN defined: two entries (main + skid), in_ready is a flop output
//     = !skid_full; no comb path out_ready->in_ready. Beat accepted while main is full and
//     not released goes to skid; on main release skid moves to main same edge. Accept +
//     release with skid full: skid->main, new beat->skid. Occupancy 0..2; flush/clr empty both.
//   Undefined: single entry, comb in_ready as in base mode; no skid storage synthesised.
// TESTING
//   1 clr=1 two cycles -> out_valid=0, out_ctrl=CTRL_BUBBLE, out_data=0, stall_cnt=0, in_ready=1.
//   2 stream 8 beats data=1..8, out_ready=1 -> outputs 1..8 one cycle later, no gaps, no drops.
//   3 beat A=0x11 held, out_ready=0 for 5 cycles -> out_data=0x11 stable, stall_cnt=5;
//     base: in_ready=0; SKID_EN: beat B=0x22 accepted then in_ready=0; release gives A then B.
//   4 flush with A held and B accepted same cycle -> next cycle out_valid=0,
//     out_ctrl=CTRL_BUBBLE; neither A nor B ever emitted; next beat C=0x33 emitted normally.
//   5 CNT_W=4, out_ready=0 for 20 cycles -> stall_cnt=15 and holds; flush does not clear it.
//   6 clr mid-stall with 2 entries (SKID_EN) -> both dropped, out_valid=0 next cycle, in_ready=1.

Source files
------------

// File: rtl/pipe_stage_hs_reg.sv
// Pipeline stage register with valid/ready handshake, flush, bubble-forced control and a
// saturating stall counter. Define PIPE_STAGE_SKID_EN for a two-entry skid variant.
module pipe_stage_hs_reg #(
  parameter int unsigned       DATA_W      = 128,
  parameter int unsigned       CTRL_W      = 12,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              accept;
  logic              release_beat;
  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  assign accept       = in_valid & in_ready;
  assign release_beat = main_valid_q & out_ready;

  always_comb begin
    stall_d = stall_q;
    if (main_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              ready_q;

  // Registered ready breaks the out_ready -> in_ready combinational path.
  assign in_ready = ready_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    if (release_beat) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        skid_valid_d = accept;
        if (accept) begin
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
        end
      end else begin
        main_valid_d = accept;
        if (accept) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end
      end
    end else if (accept) begin
      if (main_valid_q) begin
        skid_valid_d = 1'b1;
        skid_ctrl_d  = in_ctrl;
        skid_data_d  = in_data;
      end else begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl;
        main_data_d  = in_data;
      end
    end
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= CTRL_BUBBLE;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= CTRL_BUBBLE;
      skid_data_q  <= '0;
      ready_q      <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ~skid_valid_d;
    end
  end
`else
  assign in_ready = ~main_valid_q | out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    if (accept) begin
      main_valid_d = 1'b1;
      main_ctrl_d  = in_ctrl;
      main_data_d  = in_data;
    end else if (release_beat) begin
      main_valid_d = 1'b0;
    end
    if (flush) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= CTRL_BUBBLE;
      main_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
    end
  end
`endif

  assign out_valid = main_valid_q;
  assign out_ctrl  = main_valid_q ? main_ctrl_q : CTRL_BUBBLE;
  assign out_data  = main_data_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_hs_reg.sv
// Directed bench for pipe_stage_hs_reg; expectations follow the build (PIPE_STAGE_SKID_EN or not).
module tb_pipe_stage_hs_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 12;
  localparam int unsigned NW = 4;
  localparam logic [CW-1:0] BUB = '0;

  logic          clk = 1'b0;
  logic          clr, in_valid, in_ready, flush, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [NW-1:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit Skid = 1'b1;
`else
  localparam bit Skid = 1'b0;
`endif

  pipe_stage_hs_reg #(
    .DATA_W     (DW),
    .CTRL_W     (CW),
    .CTRL_BUBBLE(BUB),
    .CNT_W      (NW)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    // 1: reset
    in_ctrl = 12'hFFF; in_data = 32'hDEAD;
    cycle();
    cycle();
    clr = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_ctrl", out_ctrl, BUB);
    check("rst_data", out_data, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_ready", in_ready, 1);

    // 2: stream 8 beats
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = DW'(i); in_ctrl = CW'(12'h100 + i);
      cycle();
      check("str_valid", out_valid, 1);
      check("str_data", out_data, i);
      check("str_ctrl", out_ctrl, 12'h100 + i);
    end
    in_valid = 1'b0;
    cycle();
    check("str_drain_valid", out_valid, 0);
    check("str_drain_ctrl", out_ctrl, BUB);

    // 3: hold A under stall
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11; in_ctrl = 12'h0A5;
    cycle();
    in_data = 32'h22; in_ctrl = 12'h05A;
    check("hold_ready0", in_ready, Skid ? 1 : 0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (Skid) in_valid = 1'b0;
      check("hold_data", out_data, 32'h11);
      check("hold_ctrl", out_ctrl, 12'h0A5);
    end
    check("hold_stall", stall_cnt, 5);
    check("hold_ready", in_ready, 0);
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("rel_b_valid", out_valid, 1);
    check("rel_b_data", out_data, 32'h22);
    check("rel_b_ctrl", out_ctrl, 12'h05A);
    cycle();
    check("rel_empty", out_valid, 0);
    check("rel_stall", stall_cnt, 5);

    // 4: flush with A held, B offered the same cycle
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11; in_ctrl = 12'h0A5;
    cycle();
    in_data = 32'h22; in_ctrl = 12'h05A; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", out_valid, 0);
    check("fl_ctrl", out_ctrl, BUB);
    check("fl_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("fl_no_emit", out_valid, 0);
    end
    in_valid = 1'b1; in_data = 32'h33; in_ctrl = 12'h333;
    cycle();
    in_valid = 1'b0;
    check("fl_c_valid", out_valid, 1);
    check("fl_c_data", out_data, 32'h33);
    cycle();
    check("fl_c_gone", out_valid, 0);
    check("fl_stall", stall_cnt, 6);

    // 5: saturation, not cleared by flush
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h44; in_ctrl = 12'h444;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    check("sat_stall", stall_cnt, 15);
    check("sat_data", out_data, 32'h44);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("sat_fl_valid", out_valid, 0);
    check("sat_fl_stall", stall_cnt, 15);

    // 6: clr mid-stall
    in_valid = 1'b1; in_data = 32'h55; in_ctrl = 12'h555;
    cycle();
    if (Skid) begin
      in_data = 32'h66; in_ctrl = 12'h666;
      cycle();
      check("clr_full_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    check("clr_valid", out_valid, 0);
    check("clr_ready", in_ready, 1);
    check("clr_stall", stall_cnt, 0);
    check("clr_data", out_data, 0);
    check("clr_ctrl", out_ctrl, BUB);
    out_ready = 1'b1;
    cycle();
    check("clr_dropped", out_valid, 0);
    cycle();
    check("clr_dropped2", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
